sparse_decoder: RTL and testbench
=================================

SPARSE_DECODER -- requirements
Module: sparse_decoder

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of one activation byte lane.
REQ-002 Parameter: MEM_BW, default 128, width of encoded and dense words; LANES = MEM_BW/DATA_WIDTH (16).
REQ-003 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-004 Port: arst_n_in  in  1  reset, synchronous, active-low.
REQ-005 Port: encoded_input  in  MEM_BW  packed nonzero values, lane 0 = oldest.
REQ-006 Port: encoded_valid  in  1 / encoded_ready  out  1  handshake for encoded_input.
REQ-007 Port: masks_input  in  LANES  one bit per dense lane, 1 = nonzero.
REQ-008 Port: masks_last  in  1  qualifies final mask of a feature map.
REQ-009 Port: masks_valid  in  1 / masks_ready  out  1  handshake for masks_input and masks_last.
REQ-010 Port: out_dense  out  MEM_BW  reconstructed dense word.
REQ-011 Port: out_last  out  1  dense word belongs to final mask of a feature map.
REQ-012 Port: out_valid  out  1 / out_ready  in  1  handshake for out_dense and out_last.

Function
REQ-013 Transfer on any port SHALL occur on a rising edge where valid and ready are both 1.
REQ-014 Block SHALL hold an internal byte buffer of 2*LANES entries with fill counter fill (0..2*LANES), bytes consumed oldest-first.
REQ-015 encoded_ready SHALL be 1 when fill <= LANES and no last-mask consume happens that cycle; accepted word appends its LANES bytes (lane 0 first) behind existing bytes.
REQ-016 pop = popcount(masks_input); masks_ready SHALL be 1 when pop <= fill (registered fill only, not same-cycle encoded word) and (out_valid == 0 or out_ready == 1).
REQ-017 On mask consume, the oldest pop buffer bytes SHALL be placed into the lanes whose mask bit is 1, in ascending lane order; lanes with mask bit 0 SHALL be zero.
REQ-018 Latency: dense word SHALL appear on out_dense with out_valid = 1 on the cycle after mask consume; out_last = registered masks_last.
REQ-019 out_dense, out_last, out_valid SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-020 out_valid SHALL clear after an output transfer unless a new mask is consumed in the same cycle (back-to-back throughput 1 word/cycle).
REQ-021 Simultaneous encoded accept and mask consume: fill_next = fill - pop + LANES.
REQ-022 All-zero mask SHALL be consumable at fill = 0 and produce all-zero out_dense.
REQ-023 On consume with masks_last = 1, remaining buffered bytes (padding of final encoded word) SHALL be discarded: fill_next = 0; encoded_ready = 0 that cycle.
REQ-024 fill SHALL never exceed 2*LANES nor underflow; no byte SHALL be emitted twice or skipped within a feature map.

Reset
REQ-025 While arst_n_in = 0 at a rising edge: fill = 0, buffer contents don't-care, out_valid = 0, out_last = 0, out_dense = 0.
REQ-026 Reset mid-operation SHALL drop buffered bytes and any pending output word; first cycle after reset encoded_ready = 1, masks_ready = 1 only for all-zero mask.

Verification
REQ-027 Dense frame: 2 encoded words bytes 0x01..0x20, masks 0xFFFF, 0xFFFF(last) -> out_dense bytes 0x01..0x10 then 0x11..0x20, out_last on second.
REQ-028 Sparse spill: encoded bytes 0x01..0x10, masks 0x00FF, 0x0101, 0x0F00(last) -> lanes 0-7 = 0x01..0x08; lanes 0,8 = 0x09,0x0A; lanes 8-11 = 0x0B..0x0E; bytes 0x0F,0x10 discarded, fill = 0.
REQ-029 Zero mask at reset fill = 0: masks 0x0000 -> out_dense = 0 one cycle later, encoded_valid low throughout.
REQ-030 Backpressure: out_ready = 0 for 5 cycles with out_valid = 1 -> masks_ready = 0, out_dense stable; release -> throughput 1 word/cycle resumes.
REQ-031 Starvation: mask 0xFFFF with fill = 8 -> masks_ready = 0 until next encoded word accepted; word appears two cycles after encoded accept.
REQ-032 Reset asserted with fill = 12 and out_valid = 1 -> next cycle out_valid = 0, fill = 0, out_dense = 0.

Source files
------------

// File: rtl/sparse_decoder_if.sv
// Stream bundle for the sparse decoder: encoded byte words, lane masks and
// reconstructed dense words, each with its own valid/ready handshake.
interface sparse_decoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_BW     = 128
);
  localparam int LANES = MEM_BW / DATA_WIDTH;

  logic [MEM_BW-1:0] encoded_input;
  logic              encoded_valid;
  logic              encoded_ready;
  logic [LANES-1:0]  masks_input;
  logic              masks_last;
  logic              masks_valid;
  logic              masks_ready;
  logic [MEM_BW-1:0] out_dense;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output encoded_input, encoded_valid, masks_input, masks_last, masks_valid, out_ready,
    input  encoded_ready, masks_ready, out_dense, out_last, out_valid
  );

  modport slave (
    input  encoded_input, encoded_valid, masks_input, masks_last, masks_valid, out_ready,
    output encoded_ready, masks_ready, out_dense, out_last, out_valid
  );
endinterface

// File: rtl/sparse_decoder.sv
// Expands packed nonzero activation bytes into dense words using per-lane masks.
// A 2*LANES byte FIFO bridges encoded words and masks; output is one registered stage.
module sparse_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_BW     = 128
) (
  input logic             clk,
  input logic             arst_n_in,
  sparse_decoder_if.slave bus
);
  localparam int LANES = MEM_BW / DATA_WIDTH;
  localparam int DEPTH = 2 * LANES;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);

  typedef logic [CW-1:0]         cnt_t;
  typedef logic [DATA_WIDTH-1:0] byte_t;

  byte_t             buf_q [DEPTH];
  byte_t             buf_d [DEPTH];
  cnt_t              fill_q, fill_d;
  logic [MEM_BW-1:0] out_dense_q, out_dense_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;

  cnt_t              pop, pop_eff, base, gather_idx, src, wpos;
  logic              mask_fire, last_fire, enc_fire;
  logic [MEM_BW-1:0] dense;

  function automatic cnt_t popcount(input logic [LANES-1:0] m);
    cnt_t c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + cnt_t'(m[i]);
    return c;
  endfunction

  // Mask readiness looks only at the registered fill, never at a word arriving this cycle.
  assign pop             = popcount(bus.masks_input);
  assign bus.masks_ready = (pop <= fill_q) && (!out_valid_q || bus.out_ready);
  assign mask_fire       = bus.masks_valid && bus.masks_ready;
  assign last_fire       = mask_fire && bus.masks_last;
  assign bus.encoded_ready = (fill_q <= cnt_t'(LANES)) && !last_fire;
  assign enc_fire        = bus.encoded_valid && bus.encoded_ready;
  assign pop_eff         = mask_fire ? pop : '0;
  assign base            = fill_q - pop_eff;

  always_comb begin
    gather_idx = '0;
    dense      = '0;
    for (int l = 0; l < LANES; l++) begin
      if (bus.masks_input[l]) begin
        dense[l*DATA_WIDTH +: DATA_WIDTH] = buf_q[gather_idx[AW-1:0]];
        gather_idx = gather_idx + cnt_t'(1);
      end
    end
  end

  // Drop the consumed bytes from the head, then append a new word right behind the survivors.
  always_comb begin
    src  = '0;
    wpos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      src      = cnt_t'(i) + pop_eff;
      buf_d[i] = (src < cnt_t'(DEPTH)) ? buf_q[src[AW-1:0]] : buf_q[i];
    end
    if (enc_fire) begin
      for (int j = 0; j < LANES; j++) begin
        wpos = base + cnt_t'(j);
        buf_d[wpos[AW-1:0]] = bus.encoded_input[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    if (last_fire) begin
      fill_d = '0;
    end else begin
      fill_d = base;
      if (enc_fire) fill_d = fill_d + cnt_t'(LANES);
    end
  end

  always_comb begin
    out_dense_d = out_dense_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (mask_fire) begin
      out_dense_d = dense;
      out_last_d  = bus.masks_last;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      fill_q      <= '0;
      out_dense_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      out_dense_q <= out_dense_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign bus.out_dense = out_dense_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_sparse_decoder.sv
// Bench for sparse_decoder: directed scenarios plus randomized traffic checked
// against a byte-queue reference model.
module tb_sparse_decoder;
  localparam int DW = 8;
  localparam int BW = 128;
  localparam int L  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sparse_decoder_if #(.DATA_WIDTH(DW), .MEM_BW(BW)) bus ();
  sparse_decoder #(.DATA_WIDTH(DW), .MEM_BW(BW)) dut (.clk(clk), .arst_n_in(rst_n), .bus(bus));

  int tests_run = 0;
  int fails     = 0;

  logic [7:0]   mq[$];
  logic [BW:0]  exp_q[$];
  logic [BW:0]  obs_q[$];
  bit           model_ov;

  function automatic logic [BW-1:0] seq_word(input int first);
    logic [BW-1:0] w;
    for (int i = 0; i < L; i++) w[i*8 +: 8] = 8'(first + i);
    return w;
  endfunction

  task automatic idle_inputs();
    bus.encoded_valid = 1'b0;
    bus.encoded_input = '0;
    bus.masks_valid   = 1'b0;
    bus.masks_input   = '0;
    bus.masks_last    = 1'b0;
    bus.out_ready     = 1'b1;
  endtask

  task automatic clear_model();
    mq.delete();
    exp_q.delete();
    obs_q.delete();
    model_ov = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
  endtask

  // Advance one clock, updating the reference model with the transfers of that edge.
  task automatic tick();
    bit ef, mf, of;
    logic [BW-1:0] d;
    #1;
    ef = bus.encoded_valid && bus.encoded_ready;
    mf = bus.masks_valid && bus.masks_ready;
    of = bus.out_valid && bus.out_ready;
    if (of) obs_q.push_back({bus.out_last, bus.out_dense});
    if (mf) begin
      d = '0;
      for (int l = 0; l < L; l++)
        if (bus.masks_input[l] && mq.size() > 0) d[l*8 +: 8] = mq.pop_front();
      if (bus.masks_last) mq.delete();
      exp_q.push_back({bus.masks_last, d});
    end
    if (ef) for (int j = 0; j < L; j++) mq.push_back(bus.encoded_input[j*8 +: 8]);
    if (mf) model_ov = 1'b1;
    else if (of) model_ov = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    tests_run++; if (bus.out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
    tests_run++; if (bus.out_dense !== '0) begin fails++; $display("FAIL reset_out_dense got %h want 0", bus.out_dense); end
    tests_run++; if (bus.encoded_ready !== 1'b1) begin fails++; $display("FAIL reset_enc_ready got %b want 1", bus.encoded_ready); end
    bus.masks_input = 16'h0000; #1;
    tests_run++; if (bus.masks_ready !== 1'b1) begin fails++; $display("FAIL reset_mready_zero got %b want 1", bus.masks_ready); end
    bus.masks_input = 16'h0001; #1;
    tests_run++; if (bus.masks_ready !== 1'b0) begin fails++; $display("FAIL reset_mready_one got %b want 0", bus.masks_ready); end
    idle_inputs();
  endtask

  task automatic test_dense_frame();
    do_reset();
    bus.encoded_valid = 1'b1;
    bus.encoded_input = seq_word(1);  tick();
    bus.encoded_input = seq_word(17); tick();
    bus.encoded_valid = 1'b0;
    bus.masks_valid = 1'b1; bus.masks_input = 16'hFFFF; bus.masks_last = 1'b0; tick();
    tests_run++; if (bus.out_valid !== 1'b1 || bus.out_dense !== seq_word(1))
      begin fails++; $display("FAIL dense_latency got v=%b %h want v=1 %h", bus.out_valid, bus.out_dense, seq_word(1)); end
    bus.masks_last = 1'b1; tick();
    idle_inputs(); tick(); tick();
    tests_run++; if (obs_q.size() !== 2) begin fails++; $display("FAIL dense_count got %0d want 2", obs_q.size()); end
    if (obs_q.size() >= 2) begin
      tests_run++; if (obs_q[0] !== {1'b0, seq_word(1)}) begin fails++; $display("FAIL dense_w0 got %h want %h", obs_q[0], {1'b0, seq_word(1)}); end
      tests_run++; if (obs_q[1] !== {1'b1, seq_word(17)}) begin fails++; $display("FAIL dense_w1 got %h want %h", obs_q[1], {1'b1, seq_word(17)}); end
    end
  endtask

  task automatic test_sparse_spill();
    logic [BW:0] e [3];
    e[0] = '0; e[1] = '0; e[2] = '0;
    for (int i = 0; i < 8; i++) e[0][i*8 +: 8] = 8'(i + 1);
    e[1][7:0] = 8'h09; e[1][71:64] = 8'h0A;
    for (int i = 0; i < 4; i++) e[2][(8+i)*8 +: 8] = 8'(8'h0B + i);
    e[2][BW] = 1'b1;
    do_reset();
    bus.encoded_valid = 1'b1; bus.encoded_input = seq_word(1); tick();
    bus.encoded_valid = 1'b0;
    bus.masks_valid = 1'b1;
    bus.masks_input = 16'h00FF; tick();
    bus.masks_input = 16'h0101; tick();
    bus.masks_input = 16'h0F00; bus.masks_last = 1'b1; tick();
    idle_inputs(); tick(); tick();
    tests_run++; if (obs_q.size() !== 3) begin fails++; $display("FAIL spill_count got %0d want 3", obs_q.size()); end
    for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
      tests_run++; if (obs_q[k] !== e[k]) begin fails++; $display("FAIL spill_w%0d got %h want %h", k, obs_q[k], e[k]); end
    end
    bus.masks_input = 16'h0001; #1;
    tests_run++; if (bus.masks_ready !== 1'b0) begin fails++; $display("FAIL spill_discard got mready %b want 0", bus.masks_ready); end
    tests_run++; if (bus.encoded_ready !== 1'b1) begin fails++; $display("FAIL spill_enc_ready got %b want 1", bus.encoded_ready); end
    idle_inputs();
  endtask

  task automatic test_zero_mask();
    do_reset();
    bus.masks_valid = 1'b1; bus.masks_input = 16'h0000; #1;
    tests_run++; if (bus.masks_ready !== 1'b1) begin fails++; $display("FAIL zero_mready got %b want 1", bus.masks_ready); end
    tick();
    bus.masks_valid = 1'b0; #1;
    tests_run++; if (bus.out_valid !== 1'b1 || bus.out_dense !== '0)
      begin fails++; $display("FAIL zero_out got v=%b %h want v=1 0", bus.out_valid, bus.out_dense); end
    idle_inputs(); tick();
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] w0;
    w0 = '0;
    for (int i = 0; i < 4; i++) w0[i*8 +: 8] = 8'(i + 1);
    do_reset();
    bus.encoded_valid = 1'b1;
    bus.encoded_input = seq_word(1);  tick();
    bus.encoded_input = seq_word(17); tick();
    bus.encoded_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.masks_valid = 1'b1; bus.masks_input = 16'h000F; tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      tests_run++; if (bus.masks_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_dense !== w0)
        begin fails++; $display("FAIL bp_stall%0d got mr=%b v=%b %h want mr=0 v=1 %h", c, bus.masks_ready, bus.out_valid, bus.out_dense, w0); end
      tick();
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      tests_run++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_stream%0d got v=%b want 1", c, bus.out_valid); end
    end
    idle_inputs(); tick(); tick();
    tests_run++; if (obs_q.size() !== 8) begin fails++; $display("FAIL bp_count got %0d want 8", obs_q.size()); end
    for (int k = 0; k < 8 && k < obs_q.size(); k++) begin
      logic [BW:0] e;
      e = '0;
      for (int i = 0; i < 4; i++) e[i*8 +: 8] = 8'(4*k + i + 1);
      tests_run++; if (obs_q[k] !== e) begin fails++; $display("FAIL bp_w%0d got %h want %h", k, obs_q[k], e); end
    end
  endtask

  task automatic test_starvation();
    do_reset();
    bus.encoded_valid = 1'b1; bus.encoded_input = seq_word(1); tick();
    bus.encoded_valid = 1'b0;
    bus.masks_valid = 1'b1; bus.masks_input = 16'h00FF; tick();
    bus.masks_input = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++; if (bus.masks_ready !== 1'b0) begin fails++; $display("FAIL starve_wait%0d got mr=%b want 0", c, bus.masks_ready); end
      tick();
    end
    bus.encoded_valid = 1'b1; bus.encoded_input = seq_word(17); tick();
    bus.encoded_valid = 1'b0; #1;
    tests_run++; if (bus.masks_ready !== 1'b1 || bus.out_valid !== 1'b0)
      begin fails++; $display("FAIL starve_after_accept got mr=%b v=%b want mr=1 v=0", bus.masks_ready, bus.out_valid); end
    tick();
    tests_run++; if (bus.out_valid !== 1'b1 || bus.out_dense !== seq_word(9))
      begin fails++; $display("FAIL starve_word got v=%b %h want v=1 %h", bus.out_valid, bus.out_dense, seq_word(9)); end
    idle_inputs(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.encoded_valid = 1'b1; bus.encoded_input = seq_word(1); tick();
    bus.encoded_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.masks_valid = 1'b1; bus.masks_input = 16'h000F; tick();
    bus.masks_valid = 1'b0; #1;
    tests_run++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL rmid_pre got v=%b want 1", bus.out_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
    tests_run++; if (bus.out_valid !== 1'b0 || bus.out_dense !== '0 || bus.out_last !== 1'b0)
      begin fails++; $display("FAIL rmid_out got v=%b l=%b %h want 0 0 0", bus.out_valid, bus.out_last, bus.out_dense); end
    bus.masks_input = 16'h0001; #1;
    tests_run++; if (bus.masks_ready !== 1'b0 || bus.encoded_ready !== 1'b1)
      begin fails++; $display("FAIL rmid_fill got mr=%b er=%b want mr=0 er=1", bus.masks_ready, bus.encoded_ready); end
    idle_inputs();
  endtask

  task automatic test_random();
    bit exp_mr, exp_er;
    int mode;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.encoded_valid = ($urandom_range(0, 3) != 0);
      bus.encoded_input = {$urandom, $urandom, $urandom, $urandom};
      bus.masks_valid   = ($urandom_range(0, 2) != 0);
      mode = $urandom_range(0, 3);
      case (mode)
        0:       bus.masks_input = 16'($urandom);
        1:       bus.masks_input = 16'($urandom & $urandom);
        2:       bus.masks_input = 16'hFFFF;
        default: bus.masks_input = 16'h0000;
      endcase
      bus.masks_last = ($urandom_range(0, 7) == 0);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      #1;
      exp_mr = ($countones(bus.masks_input) <= mq.size()) && (!model_ov || bus.out_ready);
      exp_er = (mq.size() <= L) && !(bus.masks_valid && exp_mr && bus.masks_last);
      tests_run++; if (bus.masks_ready !== exp_mr) begin fails++; $display("FAIL rnd_mready c=%0d got %b want %b", c, bus.masks_ready, exp_mr); end
      tests_run++; if (bus.encoded_ready !== exp_er) begin fails++; $display("FAIL rnd_eready c=%0d got %b want %b", c, bus.encoded_ready, exp_er); end
      tests_run++; if (bus.out_valid !== model_ov) begin fails++; $display("FAIL rnd_ovalid c=%0d got %b want %b", c, bus.out_valid, model_ov); end
      tick();
    end
    idle_inputs(); tick(); tick(); tick();
    tests_run++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL rnd_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      tests_run++; if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL rnd_word%0d got %h want %h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    clear_model();
    test_reset();
    test_dense_frame();
    test_sparse_spill();
    test_zero_mask();
    test_backpressure();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
